// File: rtl/uart_frame_loader.sv
// Parses SYNC/command/payload frames from the UART byte stream into frame-buffer writes.
// Optional trailing XOR checksum byte enabled by defining RX_CHECKSUM_EN.
module uart_frame_loader #(
  parameter int          NUM_PIXELS = 19200,
  parameter int          ADDR_WIDTH = 15,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [7:0]            cmd,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);

`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, CMD, DATA, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
`endif

  state_t                state, state_next;
  logic                  we_next, busy_next, done_next;
  logic [ADDR_WIDTH-1:0] addr_next, pix_count, count_next;
  logic [7:0]            wdata_next, cmd_next;

`ifdef RX_CHECKSUM_EN
  logic [7:0] xor_acc, xor_next;
  logic       err_next;
`endif

  // Every output is registered so each write lands exactly one cycle after its strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      cmd        <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_count  <= '0;
`ifdef RX_CHECKSUM_EN
      xor_acc     <= 8'h00;
      frame_error <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      mem_we     <= we_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      cmd        <= cmd_next;
      busy       <= busy_next;
      frame_done <= done_next;
      pix_count  <= count_next;
`ifdef RX_CHECKSUM_EN
      xor_acc     <= xor_next;
      frame_error <= err_next;
`endif
    end
  end

`ifndef RX_CHECKSUM_EN
  assign frame_error = 1'b0;
`endif

  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    cmd_next   = cmd;
    busy_next  = busy;
    done_next  = 1'b0;
    count_next = pix_count;
`ifdef RX_CHECKSUM_EN
    xor_next = xor_acc;
    err_next = 1'b0;
`endif

    case (state)
      IDLE: begin
        count_next = '0;
`ifdef RX_CHECKSUM_EN
        xor_next = 8'h00;
`endif
        if (rx_ready && rx_data == SYNC_BYTE) begin
          state_next = CMD;
          busy_next  = 1'b1;
        end
      end

      CMD: begin
        if (rx_ready) begin
          cmd_next   = rx_data;
          state_next = DATA;
`ifdef RX_CHECKSUM_EN
          xor_next = rx_data;
`endif
        end
      end

      DATA: begin
        // SYNC_BYTE is ordinary payload here; only the byte count ends the frame.
        if (rx_ready) begin
          we_next    = 1'b1;
          addr_next  = pix_count;
          wdata_next = rx_data;
`ifdef RX_CHECKSUM_EN
          xor_next = xor_acc ^ rx_data;
`endif
          if (pix_count == LAST_IDX) begin
            count_next = '0;
`ifdef RX_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = IDLE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
`endif
          end else begin
            count_next = pix_count + ADDR_WIDTH'(1);
          end
        end
      end

`ifdef RX_CHECKSUM_EN
      CHECK: begin
        if (rx_ready) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          if (rx_data == xor_acc) done_next = 1'b1;
          else                    err_next  = 1'b1;
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader (NUM_PIXELS=4); checksum scenarios follow RX_CHECKSUM_EN.
module tb_uart_frame_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       mem_we;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] cmd;
  logic       busy;
  logic       frame_done;
  logic       frame_error;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  // kind 1 = frame_done, 2 = frame_error
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] cmd;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];

  uart_frame_loader #(.NUM_PIXELS(4), .ADDR_WIDTH(2), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cmd(cmd),
    .busy(busy), .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Bytes are presented on consecutive cycles when burst=1, else with one idle cycle between.
  task automatic applyStimulus(input logic [7:0] bytes[$], input bit burst);
    foreach (bytes[i]) begin
      @(negedge clk);
      rx_data  = bytes[i];
      rx_ready = 1'b1;
      if (!burst) begin
        @(negedge clk);
        rx_ready = 1'b0;
      end
    end
    if (burst) begin
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic expectFrame(input logic [7:0] c, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3, input logic [1:0] kind);
    wr_q.push_back('{2'd0, p0});
    wr_q.push_back('{2'd1, p1});
    wr_q.push_back('{2'd2, p2});
    wr_q.push_back('{2'd3, p3});
    ev_q.push_back('{kind, c});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a frame pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write", {22'd0, mem_addr, mem_wdata}, 32'hFFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          checkOutput("write_addr", {30'd0, mem_addr}, {30'd0, w.addr});
          checkOutput("write_data", {24'd0, mem_wdata}, {24'd0, w.data});
        end
      end
      if (frame_done && frame_error)
        checkOutput("done_and_error", 32'd1, 32'd0);
      if (frame_done || frame_error) begin
        if (ev_q.size() == 0) begin
          checkOutput("unexpected_pulse", {30'd0, frame_error, frame_done}, 32'd0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          checkOutput("pulse_kind", {30'd0, frame_error, frame_done}, {30'd0, e.kind});
          checkOutput("frame_cmd", {24'd0, cmd}, {24'd0, e.cmd});
          checkOutput("busy_at_end", {31'd0, busy}, 32'd0);
`ifndef RX_CHECKSUM_EN
          checkOutput("done_with_last_we", {29'd0, mem_we, mem_addr}, 32'h7);
`else
          checkOutput("done_after_last_we", {31'd0, mem_we}, 32'd0);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    idle(3);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_addr", {30'd0, mem_addr}, 32'd0);
    checkOutput("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("rst_cmd", {24'd0, cmd}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_error", {31'd0, frame_error}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Scenario 1: basic frame, busy rises the cycle after SYNC
`ifdef RX_CHECKSUM_EN
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd1);
`else
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd1);
`endif
    applyStimulus('{8'hAA}, 1'b0);
    checkOutput("busy_after_sync", {31'd0, busy}, 32'd1);
`ifdef RX_CHECKSUM_EN
    applyStimulus('{8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45}, 1'b0);
`else
    applyStimulus('{8'h05, 8'h10, 8'h20, 8'h30, 8'h40}, 1'b0);
`endif
    idle(3);
    checkOutput("busy_idle_s1", {31'd0, busy}, 32'd0);
    checkOutput("addr_hold_s1", {30'd0, mem_addr}, 32'd3);

`ifdef RX_CHECKSUM_EN
    // Scenario 2: wrong checksum -> error pulse only
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd2);
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00}, 1'b0);
    idle(3);
    checkOutput("busy_idle_s2", {31'd0, busy}, 32'd0);
`endif

    // Scenario 3: leading garbage is discarded
    applyStimulus('{8'h00, 8'hFF, 8'h55}, 1'b0);
    checkOutput("busy_garbage", {31'd0, busy}, 32'd0);
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd1);
`ifdef RX_CHECKSUM_EN
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45}, 1'b0);
`else
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40}, 1'b0);
`endif
    idle(3);

    // Scenario 4: SYNC value inside payload is data
    expectFrame(8'h01, 8'hAA, 8'hAA, 8'h03, 8'h04, 2'd1);
`ifdef RX_CHECKSUM_EN
    applyStimulus('{8'hAA, 8'h01, 8'hAA, 8'hAA, 8'h03, 8'h04, 8'h06}, 1'b0);
`else
    applyStimulus('{8'hAA, 8'h01, 8'hAA, 8'hAA, 8'h03, 8'h04}, 1'b0);
`endif
    idle(3);

    // Scenario 5: reset mid-frame aborts, next frame starts at address 0
    wr_q.push_back('{2'd0, 8'h10});
    applyStimulus('{8'hAA, 8'h05, 8'h10}, 1'b0);
    idle(1);
    reset = 1'b0;
    idle(2);
    checkOutput("mid_rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("mid_rst_addr", {30'd0, mem_addr}, 32'd0);
    checkOutput("mid_rst_wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("mid_rst_cmd", {24'd0, cmd}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(1);
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd1);
`ifdef RX_CHECKSUM_EN
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45}, 1'b0);
`else
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40}, 1'b0);
`endif
    idle(3);

    // Scenario 6: back-to-back strobes, second frame SYNC right after first ends
    expectFrame(8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 2'd1);
    expectFrame(8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 2'd1);
`ifdef RX_CHECKSUM_EN
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45,
                    8'hAA, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03}, 1'b1);
`else
    applyStimulus('{8'hAA, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40,
                    8'hAA, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b1);
`endif
    idle(4);
    checkOutput("busy_final", {31'd0, busy}, 32'd0);

    checkOutput("writes_left", wr_q.size(), 32'd0);
    checkOutput("pulses_left", ev_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
